// File: rtl/cog_pin_sync.sv
// cog_pin_sync: two-flop synchronizer for the 32 cog pad inputs, followed by a
// per-pin stability filter with a programmable mask and threshold.
// Optional build macro COG_PIN_SYNC_EDGE_EN adds registered rise/fall pulses.
// Without the macro, pin_rise and pin_fall are tied to zero.
module cog_pin_sync (
  input  logic        clk_cog,
  input  logic        res,
  input  logic [31:0] pin_raw,
  input  logic [31:0] data,
  input  logic        setmsk,
  input  logic        setthr,
  output logic [31:0] pin_in,
  output logic [31:0] pin_inb,
  output logic [31:0] pin_rise,
  output logic [31:0] pin_fall
);

  logic [31:0]      s1;
  logic [31:0]      s2;
  logic [31:0]      msk;
  logic [3:0]       thr;
  logic [31:0][3:0] cnt;
  logic [31:0][3:0] cnt_nxt;
  logic [31:0]      pin_nxt;
  logic [4:0]       thr_eff;

  // A threshold of zero behaves like one, so a filtered pin can never stall.
  assign thr_eff = (thr == 4'd0) ? 5'd1 : {1'b0, thr};

  // Per-pin filter decision; the 5-bit compare keeps cnt+1 from wrapping.
  always_comb begin
    pin_nxt = pin_in;
    cnt_nxt = '0;
    for (int n = 0; n < 32; n++) begin
      if (!msk[n]) begin
        pin_nxt[n] = s2[n];
      end else if (s2[n] != pin_in[n]) begin
        if (({1'b0, cnt[n]} + 5'd1) >= thr_eff) begin
          pin_nxt[n] = s2[n];
        end else begin
          cnt_nxt[n] = cnt[n] + 4'd1;
        end
      end
    end
  end

  // Synchronizer, filter state and configuration registers.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      s1     <= '0;
      s2     <= '0;
      pin_in <= '0;
      cnt    <= '0;
      msk    <= '0;
      thr    <= '0;
    end else begin
      s1     <= pin_raw;
      s2     <= s1;
      pin_in <= pin_nxt;
      cnt    <= setmsk ? '0 : cnt_nxt;
      if (setmsk) begin
        msk <= data;
      end
      if (setthr) begin
        thr <= data[3:0];
      end
    end
  end

  assign pin_inb = ~pin_in;

`ifdef COG_PIN_SYNC_EDGE_EN
  // Edge pulses line up with the cycle pin_in first shows its new value.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      pin_rise <= '0;
      pin_fall <= '0;
    end else begin
      pin_rise <= pin_nxt & ~pin_in;
      pin_fall <= ~pin_nxt & pin_in;
    end
  end
`else
  assign pin_rise = '0;
  assign pin_fall = '0;
`endif

endmodule

// File: tb/tb_cog_pin_sync.sv
// Testbench for cog_pin_sync: a cycle model pushes expected outputs into a
// scoreboard queue as each vector is driven; they are popped and compared
// after the clock edge. Directed constant checks cover the key latencies.
module tb_cog_pin_sync;

`ifdef COG_PIN_SYNC_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk_cog = 1'b0;
  logic        res     = 1'b1;
  logic [31:0] pin_raw = '0;
  logic [31:0] data    = '0;
  logic        setmsk  = 1'b0;
  logic        setthr  = 1'b0;
  logic [31:0] pin_in;
  logic [31:0] pin_inb;
  logic [31:0] pin_rise;
  logic [31:0] pin_fall;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pin;
    logic [31:0] rise;
    logic [31:0] fall;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] m_s1, m_s2, m_pin, m_msk;
  logic [3:0]  m_thr;
  int          m_cnt[32];
  logic [31:0] cur_raw;

  cog_pin_sync dut (
    .clk_cog  (clk_cog),
    .res      (res),
    .pin_raw  (pin_raw),
    .data     (data),
    .setmsk   (setmsk),
    .setthr   (setthr),
    .pin_in   (pin_in),
    .pin_inb  (pin_inb),
    .pin_rise (pin_rise),
    .pin_fall (pin_fall)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1  = '0;
    m_s2  = '0;
    m_pin = '0;
    m_msk = '0;
    m_thr = '0;
    for (int n = 0; n < 32; n++) m_cnt[n] = 0;
  endtask

  task automatic model_edge(input logic [31:0] raw, input logic [31:0] dat,
                            input logic sm, input logic st, output exp_t e);
    int          teff;
    logic [31:0] np;
    teff = (m_thr == 4'd0) ? 1 : int'(m_thr);
    np   = m_pin;
    for (int n = 0; n < 32; n++) begin
      if (!m_msk[n]) begin
        np[n]    = m_s2[n];
        m_cnt[n] = 0;
      end else if (m_s2[n] == m_pin[n]) begin
        m_cnt[n] = 0;
      end else if (m_cnt[n] + 1 >= teff) begin
        np[n]    = m_s2[n];
        m_cnt[n] = 0;
      end else begin
        m_cnt[n] = m_cnt[n] + 1;
      end
    end
    if (sm) begin
      for (int n = 0; n < 32; n++) m_cnt[n] = 0;
      m_msk = dat;
    end
    if (st) m_thr = dat[3:0];
    e.pin  = np;
    e.rise = EDGE_EN ? (np & ~m_pin) : 32'h0;
    e.fall = EDGE_EN ? (~np & m_pin) : 32'h0;
    m_pin  = np;
    m_s2   = m_s1;
    m_s1   = raw;
  endtask

  // One clock: drive at negedge, predict, then compare just after posedge.
  task automatic step(input logic [31:0] raw, input logic [31:0] dat,
                      input logic sm, input logic st);
    exp_t e;
    exp_t g;
    @(negedge clk_cog);
    pin_raw = raw;
    data    = dat;
    setmsk  = sm;
    setthr  = st;
    cur_raw = raw;
    model_edge(raw, dat, sm, st, e);
    sb_q.push_back(e);
    @(posedge clk_cog);
    #1;
    g = sb_q.pop_front();
    chk("sb_pin_in", pin_in, g.pin);
    chk("sb_pin_inb", pin_inb, ~g.pin);
    chk("sb_pin_rise", pin_rise, g.rise);
    chk("sb_pin_fall", pin_fall, g.fall);
    chk("sb_no_both", pin_rise & pin_fall, 32'h0);
  endtask

  task automatic run(input logic [31:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] e_one;
    logic [31:0] e_b4;
    e_one = EDGE_EN ? 32'h1 : 32'h0;
    e_b4  = EDGE_EN ? 32'h10 : 32'h0;
    cur_raw = '0;
    model_reset();

    // Reset state, held across clock edges.
    @(posedge clk_cog);
    @(posedge clk_cog);
    #1;
    chk("rst_pin_in", pin_in, 32'h0);
    chk("rst_pin_inb", pin_inb, 32'hFFFF_FFFF);
    chk("rst_pin_rise", pin_rise, 32'h0);
    chk("rst_pin_fall", pin_fall, 32'h0);
    res = 1'b0;

    // Unfiltered latency: three edges, single-cycle rise pulse.
    step(32'h1, 32'h0, 1'b0, 1'b0);
    step(32'h1, 32'h0, 1'b0, 1'b0);
    chk("unf_e2_pin", pin_in, 32'h0);
    step(32'h1, 32'h0, 1'b0, 1'b0);
    chk("unf_e3_pin", pin_in, 32'h1);
    chk("unf_e3_rise", pin_rise, e_one);
    step(32'h1, 32'h0, 1'b0, 1'b0);
    chk("unf_e4_rise", pin_rise, 32'h0);

    // Filter pin 4, threshold 4.
    step(32'h1, 32'h10, 1'b1, 1'b0);
    step(32'h1, 32'h4, 1'b0, 1'b1);

    // Filtered commit after edge 6, not edge 5.
    run(32'h11, 5);
    chk("flt_e5_pin4", pin_in & 32'h10, 32'h0);
    step(32'h11, 32'h0, 1'b0, 1'b0);
    chk("flt_e6_pin4", pin_in & 32'h10, 32'h10);
    chk("flt_e6_rise4", pin_rise & 32'h10, e_b4);
    run(32'h1, 8);
    chk("flt_back_low", pin_in & 32'h10, 32'h0);

    // Glitch of three cycles is rejected.
    for (int i = 0; i < 11; i++) begin
      step((i < 3) ? 32'h11 : 32'h1, 32'h0, 1'b0, 1'b0);
      chk("glitch_pin4", pin_in & 32'h10, 32'h0);
      chk("glitch_rise4", pin_rise & 32'h10, 32'h0);
    end
    // Count restarted from zero: a held change again needs six edges.
    run(32'h11, 5);
    chk("glitch_hold_e5", pin_in & 32'h10, 32'h0);
    step(32'h11, 32'h0, 1'b0, 1'b0);
    chk("glitch_hold_e6", pin_in & 32'h10, 32'h10);
    run(32'h1, 8);

    // Threshold zero acts like an unfiltered pin.
    step(32'h1, 32'h0, 1'b0, 1'b1);
    run(32'h11, 2);
    chk("thr0_e2_pin4", pin_in & 32'h10, 32'h0);
    step(32'h11, 32'h0, 1'b0, 1'b0);
    chk("thr0_e3_pin4", pin_in & 32'h10, 32'h10);

    // Threshold lowered from 15 to 2 mid-count.
    step(32'h11, 32'hF, 1'b0, 1'b1);
    run(32'h1, 7);
    chk("thrlow_pre", pin_in & 32'h10, 32'h10);
    step(32'h1, 32'h2, 1'b0, 1'b1);
    chk("thrlow_load_edge", pin_in & 32'h10, 32'h10);
    step(32'h1, 32'h0, 1'b0, 1'b0);
    chk("thrlow_commit", pin_in & 32'h10, 32'h0);
    chk("thrlow_fall4", pin_fall & 32'h10, e_b4);

    // Reset in the middle of a count.
    step(32'h1, 32'h4, 1'b0, 1'b1);
    run(32'h11, 5);
    @(negedge clk_cog);
    res = 1'b1;
    #1;
    model_reset();
    chk("midrst_pin_in", pin_in, 32'h0);
    chk("midrst_pin_inb", pin_inb, 32'hFFFF_FFFF);
    chk("midrst_rise", pin_rise, 32'h0);
    chk("midrst_fall", pin_fall, 32'h0);
    @(posedge clk_cog);
    #1;
    chk("midrst_hold_pin", pin_in, 32'h0);
    res = 1'b0;
    step(32'h11, 32'h10, 1'b1, 1'b0);
    step(32'h11, 32'h4, 1'b0, 1'b1);
    step(32'h11, 32'h0, 1'b0, 1'b0);
    chk("postrst_pin0", pin_in & 32'h1, 32'h1);
    chk("postrst_rise0", pin_rise & 32'h1, e_one);
    run(32'h11, 2);
    chk("postrst_e5_pin4", pin_in & 32'h10, 32'h0);
    step(32'h11, 32'h0, 1'b0, 1'b0);
    chk("postrst_e6_pin4", pin_in & 32'h10, 32'h10);

    // Mask and threshold loaded together, then random traffic.
    step(cur_raw, 32'h0000_0013, 1'b1, 1'b1);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] r;
      logic        sm;
      logic        st;
      r  = cur_raw ^ ($urandom & $urandom & $urandom);
      sm = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 7) == 0);
      step(r, $urandom, sm, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cog_pin_sync.md
COG_PIN_SYNC -- requirements
Module: cog_pin_sync

Interface
REQ-001 clk_cog  input  1  cog clock; every register in the block changes only on its rising edge, except on reset.
REQ-002 res  input  1  asynchronous, active-high reset.
REQ-003 pin_raw  input  32  asynchronous pad inputs.
REQ-004 data  input  32  configuration write data.
REQ-005 setmsk  input  1  on a rising edge, loads the filter mask from data[31:0]; bit n=1 filters pin n.
REQ-006 setthr  input  1  on a rising edge, loads the filter threshold from data[3:0].
REQ-007 pin_in  output  32  synchronized, filtered pin state; consumed by the counter stage as its pin_in.
REQ-008 pin_inb  output  32  bitwise inverse of pin_in.
REQ-009 pin_rise  output  32  one-cycle pulse on a pin_in 0->1 transition.
REQ-010 pin_fall  output  32  one-cycle pulse on a pin_in 1->0 transition.

Function
REQ-011 Each pin passes through two flops, s1 <= pin_raw, then s2 <= s1, before any logic.
REQ-012 Unfiltered pin (mask bit 0): pin_in[n] <= s2[n] every cycle. A pin_raw change set up before edge 1 appears on pin_in after edge 3.
REQ-013 Effective threshold T = thr, except thr=0 gives T=1.
REQ-014 Each filtered pin has a 4-bit stability counter cnt[n].
REQ-015 Filtered pin, s2[n]==pin_in[n]: cnt[n] <= 0.
REQ-016 Filtered pin, s2[n]!=pin_in[n] and cnt[n]+1 >= T: pin_in[n] <= s2[n] and cnt[n] <= 0.
REQ-017 Filtered pin, s2[n]!=pin_in[n] and cnt[n]+1 < T: cnt[n] <= cnt[n]+1, with no wrap.
REQ-018 Filtered-pin latency: a change set up before edge 1 and held reaches pin_in after edge 2+T.
REQ-019 An s2 excursion shorter than T cycles never reaches pin_in.
REQ-020 The >= compare means that lowering thr mid-count lets a pending mismatch commit on the next mismatching edge.
REQ-021 Unfiltered pins hold cnt[n]=0.
REQ-022 setmsk clears all cnt[] in the same edge it loads the mask.
REQ-023 The new mask takes effect from the edge after the load, with no spurious pin_in change.
REQ-024 setmsk and setthr asserted together both load; the new threshold first applies on the following edge.
REQ-025 pin_rise[n] and pin_fall[n] are registered and assert in the same cycle pin_in[n] first shows the new value.
REQ-026 pin_rise[n] and pin_fall[n] each last exactly one cycle and are never both high.
REQ-027 pin_inb is combinational ~pin_in and has no extra latency.

Reset
REQ-028 While res is high: s1, s2, pin_in, pin_rise, pin_fall, all cnt[], the mask and thr are all 0, and pin_inb is all 1s.
REQ-029 res asserted mid-filter discards partial counts immediately.
REQ-030 After res deasserts, pins at 1 produce pin_rise pulses when they propagate, with the REQ-012/REQ-018 latency.

Configuration
REQ-031 Macro COG_PIN_SYNC_EDGE_EN defined: pin_rise and pin_fall behave per REQ-025 and REQ-026.
REQ-032 Macro COG_PIN_SYNC_EDGE_EN undefined: the pin_rise and pin_fall ports remain but are tied to 32'b0, and no edge registers are built.

Verification
REQ-033 Unfiltered latency: after reset, pin_raw=32'h0000_0001 before edge 1 -> pin_in=32'h1 after edge 3, pin_rise=32'h1 for that single cycle only.
REQ-034 Filtered commit: mask=32'h0000_0010, thr=4; pin_raw[4] rises before edge 1 -> pin_in[4]=1 after edge 6 with pin_rise[4] pulse, and not after edge 5.
REQ-035 Glitch rejection: same configuration as REQ-034; pin_raw[4] high for 3 cycles -> pin_in[4] stays 0, no pulses, cnt[4] returns to 0.
REQ-036 Threshold edge case: thr=0, pin 4 filtered -> same 3-edge latency as an unfiltered pin.
REQ-037 Threshold lowered mid-count: thr=15, cnt[4] reaches 5, then thr=2 -> pin_in[4] commits on the next mismatching edge.
REQ-038 Reset mid-count: res pulsed with cnt[4]=3 -> all outputs 0, pin_inb=32'hFFFF_FFFF, and the count restarts from 0 once res is released.
